// File: rtl/fetch_mem_arbiter_if.sv
// Bundles the fetch, data and shared-RAM signals of the instruction/data memory arbiter.
// Latency: none; wires only.
// Backpressure: freeze_if / freeze_mem flow from the arbiter (slave) back to the stages (master).
interface fetch_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        freeze_if;
  logic        freeze_mem;
  logic        ram_en;
  logic        ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, flush, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, ram_rdata,
    output if_instr, if_ready, mem_rdata, mem_ready, freeze_if, freeze_mem,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, flush, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, ram_rdata,
    input  if_instr, if_ready, mem_rdata, mem_ready, freeze_if, freeze_mem,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Arbitrates one shared RAM port between the fetch stage and the data stage.
// Latency: grant in IDLE at t, RAM busy t+1..t+ACCESS_CYCLES, ready pulse at t+ACCESS_CYCLES+1.
// Backpressure: freeze_if / freeze_mem stall each requester until its ready pulse.
module fetch_mem_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input logic                clk,
  input logic                rst,
  fetch_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        last_mem;        // 1: last grant went to the data stage
  logic        flush_pending;
  logic [31:0] if_instr_q;
  logic [31:0] mem_rdata_q;
  logic        if_ready_q;
  logic        mem_ready_q;
  logic        if_elig;
  logic        mem_elig;
  logic        grant_if;
  logic        grant_mem;
  logic        done;
  logic        access;
  logic        fetch_cancel;

  // A requester whose ready is pulsing this cycle has just been served, so it is not re-granted.
  assign if_elig      = bus.if_req & ~if_ready_q & ~bus.flush;
  assign mem_elig     = (bus.mem_rd_en | bus.mem_wr_en) & ~mem_ready_q;
  assign fetch_cancel = flush_pending | bus.flush;
  assign access       = (state != IDLE);

  // Next state: alternate on contention, return to IDLE once the counter has run out.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (if_elig && (!mem_elig || last_mem)) begin
          grant_if  = 1'b1;
          state_nxt = IF_ACC;
        end else if (mem_elig) begin
          grant_mem = 1'b1;
          state_nxt = MEM_ACC;
        end
      end
      IF_ACC, MEM_ACC: begin
        if (cnt == 4'd0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latch the granted request and count down the access; inputs are ignored while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= 4'd0;
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      last_mem      <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      if (grant_if) begin
        addr_q   <= bus.if_addr[31:2];
        wdata_q  <= '0;
        we_q     <= 1'b0;
        cnt      <= CNT_INIT;
        last_mem <= 1'b0;
      end else if (grant_mem) begin
        addr_q   <= bus.mem_addr[31:2];
        wdata_q  <= bus.mem_wdata;
        we_q     <= bus.mem_wr_en;  // read+write together counts as a store
        cnt      <= CNT_INIT;
        last_mem <= 1'b1;
      end else if (access && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (done)                              flush_pending <= 1'b0;
      else if (state == IF_ACC && bus.flush) flush_pending <= 1'b1;
    end
  end

  // Capture read data on the last access cycle and pulse the matching ready one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_instr_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if (done && state == IF_ACC && !fetch_cancel) begin
        if_instr_q <= bus.ram_rdata;
        if_ready_q <= 1'b1;
      end
      if (done && state == MEM_ACC) begin
        mem_ready_q <= 1'b1;
        if (!we_q) mem_rdata_q <= bus.ram_rdata;
      end
    end
  end

  assign bus.if_instr   = if_instr_q;
  assign bus.if_ready   = if_ready_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.mem_ready  = mem_ready_q;
  assign bus.freeze_if  = bus.if_req & ~if_ready_q;
  assign bus.freeze_mem = (bus.mem_rd_en | bus.mem_wr_en) & ~mem_ready_q;
  assign bus.ram_en     = access;
  assign bus.ram_we     = (state == MEM_ACC) & we_q;
  assign bus.ram_addr   = access ? addr_q : '0;
  assign bus.ram_wdata  = access ? wdata_q : '0;
endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed scenarios with literal expectations plus random traffic.
// Latency: a cycle-indexed model predicts every output each cycle.
// Backpressure: freeze outputs are predicted from the requests and predicted ready pulses.
module tb_fetch_mem_arbiter;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  bit   checking = 1'b0;
  int   rst_hold = 0;
  logic [1:0] r;

  fetch_mem_arbiter_if bus();

  fetch_mem_arbiter #(.ACCESS_CYCLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: an access granted at the end of cycle c owns the RAM for cycles
  // c+1..c+N and its result appears at cycle c+N+1.
  longint      cyc = 0;
  int          m_kind = 0;          // 0 none, 1 fetch, 2 data
  longint      m_end = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic        m_we = 1'b0;
  logic        m_flushed = 1'b0;
  logic        m_last_mem = 1'b0;
  longint      m_if_rdy_at = -1;
  longint      m_mem_rdy_at = -1;
  logic [31:0] m_if_instr = '0;
  logic [31:0] m_mem_rdata = '0;

  wire if_el  = bus.if_req && (m_if_rdy_at != cyc) && !bus.flush;
  wire mem_el = (bus.mem_rd_en || bus.mem_wr_en) && (m_mem_rdy_at != cyc);
  wire go_if  = if_el && (!mem_el || m_last_mem);
  wire go_mem = mem_el && !go_if;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_kind       <= 0;
      m_flushed    <= 1'b0;
      m_last_mem   <= 1'b0;
      m_if_rdy_at  <= -1;
      m_mem_rdy_at <= -1;
      m_if_instr   <= '0;
      m_mem_rdata  <= '0;
    end else if (m_kind != 0) begin
      if (m_kind == 1 && bus.flush) m_flushed <= 1'b1;
      if (cyc == m_end) begin
        m_kind    <= 0;
        m_flushed <= 1'b0;
        if (m_kind == 1) begin
          if (!(m_flushed || bus.flush)) begin
            m_if_instr  <= bus.ram_rdata;
            m_if_rdy_at <= cyc + 1;
          end
        end else begin
          if (!m_we) m_mem_rdata <= bus.ram_rdata;
          m_mem_rdy_at <= cyc + 1;
        end
      end
    end else if (go_if) begin
      m_kind <= 1; m_addr <= bus.if_addr; m_wdata <= '0; m_we <= 1'b0;
      m_last_mem <= 1'b0; m_end <= cyc + N;
    end else if (go_mem) begin
      m_kind <= 2; m_addr <= bus.mem_addr; m_wdata <= bus.mem_wdata; m_we <= bus.mem_wr_en;
      m_last_mem <= 1'b1; m_end <= cyc + N;
    end
  end

  // Compare every DUT output against the model once per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (checking) begin
      check("if_ready",   32'(bus.if_ready),   32'(!rst && m_if_rdy_at == cyc));
      check("mem_ready",  32'(bus.mem_ready),  32'(!rst && m_mem_rdy_at == cyc));
      check("if_instr",   bus.if_instr,        rst ? 32'd0 : m_if_instr);
      check("mem_rdata",  bus.mem_rdata,       rst ? 32'd0 : m_mem_rdata);
      check("ram_en",     32'(bus.ram_en),     32'(!rst && m_kind != 0));
      check("ram_we",     32'(bus.ram_we),     32'(!rst && m_kind == 2 && m_we));
      check("ram_addr",   32'(bus.ram_addr),   (!rst && m_kind != 0) ? 32'(m_addr[31:2]) : 32'd0);
      if (!rst && m_kind == 2 && m_we) check("ram_wdata", bus.ram_wdata, m_wdata);
      else if (rst || m_kind == 0)     check("ram_wdata_idle", bus.ram_wdata, 32'd0);
      check("freeze_if",  32'(bus.freeze_if),  32'(bus.if_req && !(!rst && m_if_rdy_at == cyc)));
      check("freeze_mem", 32'(bus.freeze_mem),
            32'((bus.mem_rd_en || bus.mem_wr_en) && !(!rst && m_mem_rdy_at == cyc)));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.flush = 0; bus.mem_rd_en = 0; bus.mem_wr_en = 0;
    bus.mem_addr = 0; bus.mem_wdata = 0; bus.ram_rdata = 0;
    repeat (2) next_cycle();
    checking = 1'b1;
    settle();
    check("rst_ram_en", 32'(bus.ram_en), 32'd0);
    check("rst_if_instr", bus.if_instr, 32'd0);
    check("rst_mem_rdata", bus.mem_rdata, 32'd0);
    next_cycle(); rst = 0;

    // Single fetch: 0x10 -> word 0x4 for two cycles, instruction returned at t+3.
    bus.ram_rdata = 32'hE3A00001;
    next_cycle(); bus.if_req = 1; bus.if_addr = 32'h10;
    settle(); check("fetch_t0_en", 32'(bus.ram_en), 32'd0);
    next_cycle(); bus.if_req = 0; bus.if_addr = 32'hFFFF_FFF0;
    settle(); check("fetch_t1_addr", 32'(bus.ram_addr), 32'h4);
    next_cycle();
    settle(); check("fetch_t2_addr", 32'(bus.ram_addr), 32'h4);
    check("fetch_t2_rdy", 32'(bus.if_ready), 32'd0);
    next_cycle();
    settle(); check("fetch_t3_rdy", 32'(bus.if_ready), 32'd1);
    check("fetch_t3_instr", bus.if_instr, 32'hE3A00001);
    next_cycle();
    settle(); check("fetch_t4_rdy", 32'(bus.if_ready), 32'd0);

    // Contention after reset: MEM, IF, MEM, IF with a period of six cycles.
    next_cycle(); rst = 1;
    next_cycle(); rst = 0;
    bus.if_req = 1; bus.mem_rd_en = 1; bus.if_addr = 32'h20; bus.mem_addr = 32'h40;
    bus.ram_rdata = 32'h1111_2222;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) next_cycle();
      settle();
      case (k % 6)
        1, 2: check("alt_addr_mem", 32'(bus.ram_addr), 32'h10);
        4, 5: check("alt_addr_if", 32'(bus.ram_addr), 32'h8);
        default: check("alt_idle_en", 32'(bus.ram_en), 32'd0);
      endcase
      check("alt_mem_rdy", 32'(bus.mem_ready), 32'(k % 6 == 3));
      check("alt_if_rdy", 32'(bus.if_ready), 32'(k % 6 == 0 && k > 0));
      check("alt_freeze_if", 32'(bus.freeze_if), 32'(!(k % 6 == 0 && k > 0)));
    end
    next_cycle(); bus.if_req = 0; bus.mem_rd_en = 0;
    repeat (4) next_cycle();
    settle(); check("alt_mem_rdata", bus.mem_rdata, 32'h1111_2222);
    check("alt_if_instr", bus.if_instr, 32'h1111_2222);

    // Store: write strobe on word 0x40, completion pulse, load data untouched.
    next_cycle(); bus.mem_wr_en = 1; bus.mem_addr = 32'h100; bus.mem_wdata = 32'hDEADBEEF;
    bus.ram_rdata = 32'h5555_AAAA;
    next_cycle(); bus.mem_wr_en = 0; bus.mem_wdata = 0;
    settle(); check("st_we", 32'(bus.ram_we), 32'd1);
    check("st_addr", 32'(bus.ram_addr), 32'h40);
    check("st_wdata", bus.ram_wdata, 32'hDEADBEEF);
    next_cycle();
    settle(); check("st_we2", 32'(bus.ram_we), 32'd1);
    next_cycle();
    settle(); check("st_rdy", 32'(bus.mem_ready), 32'd1);
    check("st_rdata", bus.mem_rdata, 32'h1111_2222);

    // Flush in the first fetch cycle: access drains silently, new address fetched next.
    next_cycle(); bus.if_req = 1; bus.if_addr = 32'h200; bus.ram_rdata = 32'hAAAA_AAAA;
    next_cycle(); bus.flush = 1; bus.if_addr = 32'h300;
    settle(); check("fl_addr1", 32'(bus.ram_addr), 32'h80);
    next_cycle(); bus.flush = 0;
    settle(); check("fl_addr2", 32'(bus.ram_addr), 32'h80);
    next_cycle();
    settle(); check("fl_no_rdy", 32'(bus.if_ready), 32'd0);
    check("fl_instr_kept", bus.if_instr, 32'h1111_2222);
    next_cycle(); bus.if_req = 0;
    settle(); check("fl_new_addr", 32'(bus.ram_addr), 32'hC0);
    next_cycle();
    next_cycle();
    settle(); check("fl_rdy", 32'(bus.if_ready), 32'd1);
    check("fl_instr", bus.if_instr, 32'hAAAA_AAAA);

    // Reset in the second load cycle aborts it; the held load restarts afterwards.
    next_cycle();
    next_cycle(); bus.mem_rd_en = 1; bus.mem_addr = 32'h80; bus.ram_rdata = 32'h1234_5678;
    next_cycle();
    settle(); check("ra_addr1", 32'(bus.ram_addr), 32'h20);
    next_cycle(); rst = 1;
    settle(); check("ra_en", 32'(bus.ram_en), 32'd0);
    check("ra_addr", 32'(bus.ram_addr), 32'd0);
    check("ra_instr", bus.if_instr, 32'd0);
    next_cycle(); rst = 0;
    settle(); check("ra_no_rdy", 32'(bus.mem_ready), 32'd0);
    next_cycle();
    settle(); check("ra_regrant", 32'(bus.ram_addr), 32'h20);
    next_cycle();
    next_cycle();
    settle(); check("ra_rdy", 32'(bus.mem_ready), 32'd1);
    check("ra_rdata", bus.mem_rdata, 32'h1234_5678);
    next_cycle(); bus.mem_rd_en = 0;

    // Random traffic, including occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 0;
      end else if ($urandom_range(299) == 0) begin
        rst = 1;
        rst_hold = 2;
      end
      bus.if_req    = ($urandom_range(9) < 6);
      bus.if_addr   = $urandom;
      bus.flush     = ($urandom_range(9) == 0);
      r             = 2'($urandom_range(3));
      bus.mem_rd_en = r[0];
      bus.mem_wr_en = r[1];
      bus.mem_addr  = $urandom;
      bus.mem_wdata = $urandom;
      bus.ram_rdata = $urandom;
    end
    settle();
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
